// File: rtl/range_sweep_checker.sv
// Sweeps every WIDTH-bit code onto a DUT, samples its 1-bit response after SETTLE+1 cycles per code.
// Scores each response against the inclusive range [LO, HI]. Sweep length is 2^WIDTH*(SETTLE+1)+1 edges. There is no backpressure.
module range_sweep_checker #(
  parameter int WIDTH  = 3,
  parameter int LO     = 2,
  parameter int HI     = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             resp,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   pass_cnt,
  output logic [WIDTH:0]   fail_cnt,
  output logic             fail_seen,
  output logic [WIDTH-1:0] first_fail_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);
  localparam logic [31:0]   LO_W        = 32'(LO);
  localparam logic [31:0]   HI_W        = 32'(HI);

  state_t         state, state_nxt;
  logic [SW-1:0]  settle_cnt;
  logic [31:0]    stim_w;
  logic           sample_edge;
  logic           last_code;
  logic           expected;
  logic           launch;

  assign stim_w      = 32'(stim);
  assign sample_edge = (settle_cnt == SETTLE_LAST);
  // The sweep ends on detecting the last code, never on stim wrapping.
  assign last_code   = (stim == {WIDTH{1'b1}});
  assign expected    = (stim_w >= LO_W) && (stim_w <= HI_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (sample_edge && last_code) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim            <= '0;
      settle_cnt      <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      fail_seen       <= 1'b0;
      first_fail_code <= '0;
    end else if (launch) begin
      stim            <= '0;
      settle_cnt      <= '0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      fail_seen       <= 1'b0;
      first_fail_code <= '0;
    end else if (state == S_RUN) begin
      if (sample_edge) begin
        if (resp == expected) begin
          pass_cnt <= pass_cnt + 1'b1;
        end else begin
          fail_cnt <= fail_cnt + 1'b1;
          if (!fail_seen) begin
            fail_seen       <= 1'b1;
            first_fail_code <= stim;
          end
        end
        settle_cnt <= '0;
        stim       <= last_code ? '0 : stim + 1'b1;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/range_sweep_checker.md
Name: range_sweep_checker

Overview:
- Hardware stimulus/checker engine for small combinational decode blocks whose output is 1 only for input codes in an inclusive range [LO, HI].
- Sweeps every code 0..2^WIDTH-1 onto the DUT inputs, waits a settle window, samples the DUT's 1-bit response and compares it with the expected range decision.
- Accumulates pass/fail counts and the first failing code; used as on-chip BIST in place of a simulation-only bench.

Parameters:
- WIDTH, 3, stimulus code width in bits (>=1).
- LO, 2, lowest code for which a response of 1 is expected.
- HI, 5, highest code for which a response of 1 is expected; if LO>HI, expected is always 0.
- SETTLE, 1, extra cycles stim is held before resp is sampled (>=0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- resp  input  1  DUT response to stim.
- stim  output  WIDTH  code driven to the DUT.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; results valid.
- pass_cnt  output  WIDTH+1  codes whose resp matched expected.
- fail_cnt  output  WIDTH+1  codes whose resp mismatched.
- fail_seen  output  1  at least one mismatch this sweep.
- first_fail_code  output  WIDTH  first mismatching code; 0 if none.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous, active-low (rst_n sampled at clk rising edge).
- Reset: all outputs 0; state IDLE. Reset in any state, including mid-sweep, aborts the sweep and clears all results the same edge.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1; results held stable.
- Start from IDLE or DONE: start=1 at an edge -> next cycle RUN; stim=0; pass_cnt, fail_cnt, fail_seen and first_fail_code cleared; internal settle counter=0.
- start while in RUN is ignored.
- Code window:
  - Each code occupies exactly SETTLE+1 cycles with stim stable.
  - resp is sampled at the edge ending the window.
  - expected = (stim>=LO) && (stim<=HI), compared unsigned.
- At the sample edge:
  - If resp==expected, pass_cnt+1; otherwise fail_cnt+1.
  - On the first mismatch of a sweep, first_fail_code<=stim and fail_seen<=1. Later mismatches do not change first_fail_code.
  - If stim < 2^WIDTH-1: stim+1 and the settle counter restarts.
  - If stim == 2^WIDTH-1: next state DONE, and stim returns to 0.
- Wrap-around: a WIDTH-bit stim must not wrap and restart the sweep; termination is by last-code detect, not overflow.
- Counters are WIDTH+1 bits, so a count of 2^WIDTH is representable. Invariant in DONE: pass_cnt+fail_cnt == 2^WIDTH.
- Latency: start edge to done=1 is exactly 2^WIDTH*(SETTLE+1)+1 edges (last-sample edge -> DONE).
- DONE persists until start=1 or reset. start in DONE restarts the sweep, and done drops the next cycle.
- Holding start high continuously gives back-to-back sweeps, with done high for exactly 1 cycle between them.
- resp is ignored outside sample edges.

Test Plan:
1. Defaults; resp modelled as ideal (1 for codes 2..5); start pulsed 1 cycle -> stim steps 0..7, each held 2 cycles; done=1 at 17th edge after start; pass_cnt=8, fail_cnt=0, fail_seen=0, first_fail_code=0.
2. resp stuck at 0 -> pass_cnt=4, fail_cnt=4, fail_seen=1, first_fail_code=2.
3. resp stuck at 1 -> pass_cnt=4, fail_cnt=4, first_fail_code=0; verify first_fail_code stays 0 despite later mismatches.
4. Start sweep; assert rst_n=0 for 1 cycle while stim=3 -> next cycle all outputs 0, state IDLE; re-start gives full clean sweep with pass_cnt=8.
5. start held high throughout with ideal resp -> done high for exactly one cycle every 17 cycles; counters cleared at each restart; start pulses during RUN have no effect.
6. SETTLE=0, LO=6, HI=1 (empty range), resp=0 -> one cycle per code; done after 9 edges; pass_cnt=8, fail_cnt=0.
